// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the MEM stage has priority, host bursts run beat by beat.
// Define ARB_STARVE_GUARD_EN to add a starvation counter that forces a host grant.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [3:0]        host_len,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {CPU_OWN = 1'b0, HOST_BURST = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [3:0]        len_r;
  logic              dir_r;
  logic [3:0]        beat_cnt_r;
  logic              host_rvalid_r;
  logic              host_done_r;

  logic              grant_s;
  logic              last_beat_s;
  logic              starve_hit_s;
  logic [ADDR_W-1:0] beat_addr_s;
  logic              mem_en_s;
  logic              mem_we_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt_r;

  assign starve_hit_s = (starve_cnt_r == STARVE_W'(STARVE_LIMIT));

  // Count cycles a waiting host is refused; saturate at the limit, clear on grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= '0;
    end else if (grant_s) begin
      starve_cnt_r <= '0;
    end else if (host_req && (state_r == CPU_OWN) && !starve_hit_s) begin
      starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  assign grant_s     = (state_r == CPU_OWN) && host_req && (!cpu_req || starve_hit_s);
  assign last_beat_s = (state_r == HOST_BURST) && (beat_cnt_r == len_r);
  assign beat_addr_s = base_r + ADDR_W'(beat_cnt_r);

  assign host_gnt    = (state_r == HOST_BURST);
  assign cpu_stall   = host_gnt & cpu_req;
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign host_rvalid = host_rvalid_r;
  assign host_done   = host_done_r;

  // Steer the memory port to whichever side owns it this cycle.
  always_comb begin
    mem_en_s  = 1'b0;
    mem_we_s  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (state_r)
      CPU_OWN: begin
        mem_en_s  = cpu_req;
        mem_we_s  = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      HOST_BURST: begin
        mem_en_s  = 1'b1;
        mem_we_s  = dir_r;
        mem_addr  = beat_addr_s;
        mem_wdata = host_wdata;
      end
      default: begin
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Gate with reset so no stray access reaches the macro while reset is held.
  assign mem_en = mem_en_s & rst;
  assign mem_we = mem_we_s & rst;

  // Ownership FSM with burst sequencing and host status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= CPU_OWN;
      base_r        <= '0;
      len_r         <= 4'd0;
      dir_r         <= 1'b0;
      beat_cnt_r    <= 4'd0;
      host_rvalid_r <= 1'b0;
      host_done_r   <= 1'b0;
    end else begin
      host_rvalid_r <= (state_r == HOST_BURST) & ~dir_r;
      host_done_r   <= last_beat_s;
      case (state_r)
        CPU_OWN: begin
          if (grant_s) begin
            state_r    <= HOST_BURST;
            base_r     <= host_addr;
            len_r      <= host_len;
            dir_r      <= host_we;
            beat_cnt_r <= 4'd0;
          end
        end
        HOST_BURST: begin
          if (last_beat_s) begin
            state_r <= CPU_OWN;
          end else begin
            beat_cnt_r <= beat_cnt_r + 4'd1;
          end
        end
        default: state_r <= CPU_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected accesses/data,
// a negedge monitor compares them as the port presents them.
module tb_dmem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [3:0]    host_len;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_gnt, host_rvalid, host_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_done(host_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory macro stand-in.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  logic [DW-1:0] ref_mem [0:1023];

  typedef struct packed {
    logic          host;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t          exp_acc [$];
  logic [DW-1:0] exp_hrd [$];
  logic [DW-1:0] exp_crd [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic acc_t mk_acc(input logic h, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
    acc_t r;
    r.host  = h;
    r.we    = w;
    r.addr  = a;
    r.wdata = w ? d : '0;
    return r;
  endfunction

  // Monitor: compare every presented access, read data and status pulse.
  logic prev_crd = 1'b0, prev_hrd = 1'b0, prev_gnt = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_rst) begin
        if (prev_crd) begin
          if (exp_crd.size() == 0) chk("cpu_rdata_extra", 64'd1, 64'd0);
          else chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_crd.pop_front()));
        end
        chk("rvalid_lag", 64'(host_rvalid), 64'(prev_hrd));
        chk("done_timing", 64'(host_done), 64'(prev_gnt & ~host_gnt));
      end
      if (host_rvalid) begin
        if (exp_hrd.size() == 0) chk("host_rdata_extra", 64'd1, 64'd0);
        else chk("host_rdata", 64'(host_rdata), 64'(exp_hrd.pop_front()));
      end
      if (mem_en) begin
        if (exp_acc.size() == 0) chk("mem_access_extra", 64'd1, 64'd0);
        else chk("mem_access", 64'(mk_acc(host_gnt, mem_we, mem_addr, mem_wdata)),
                 64'(exp_acc.pop_front()));
      end
      prev_crd <= mem_en & ~mem_we & ~host_gnt;
      prev_hrd <= host_gnt & ~mem_we;
      prev_gnt <= host_gnt;
    end else begin
      prev_crd <= 1'b0;
      prev_hrd <= 1'b0;
      prev_gnt <= 1'b0;
    end
    prev_rst <= rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_acc.push_back(mk_acc(1'b0, we, a, d));
    if (we) ref_mem[a] = d;
    else    exp_crd.push_back(ref_mem[a]);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    push_cpu(we, a, d);
    #1;
    chk("cpu_no_stall", 64'(cpu_stall), 64'd0);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // Host burst with the CPU idle at request time; optional CPU store raised at beat cpu_beat.
  task automatic host_burst(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                            input int dbase, input int cpu_beat,
                            input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    logic [DW-1:0] d [16];
    logic [AW-1:0] ai;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = (dbase < 0) ? $urandom : DW'(dbase + i);
      ai   = addr + AW'(i);
      exp_acc.push_back(mk_acc(1'b1, we, ai, d[i]));
      if (we) ref_mem[ai] = d[i];
      else    exp_hrd.push_back(ref_mem[ai]);
    end
    host_req = 1'b1; host_we = we; host_addr = addr; host_len = len; host_wdata = d[0];
    cyc();
    host_req = 1'b0; host_we = 1'($urandom); host_addr = AW'($urandom); host_len = 4'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      host_wdata = d[i];
      if (i == cpu_beat) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ca; cpu_wdata = cd;
        push_cpu(1'b1, ca, cd);
      end
      #1;
      chk("host_gnt_beat", 64'(host_gnt), 64'd1);
      if (cpu_beat >= 0 && i >= cpu_beat) chk("cpu_stall_hold", 64'(cpu_stall), 64'd1);
      cyc();
    end
    #1;
    chk("host_gnt_end", 64'(host_gnt), 64'd0);
    chk("host_done", 64'(host_done), 64'd1);
    if (cpu_beat >= 0) begin
      chk("cpu_stall_release", 64'(cpu_stall), 64'd0);
      cyc();
      cpu_req = 1'b0; cpu_we = 1'b0;
    end
  endtask

  // CPU requests every cycle while the host waits for the port.
  task automatic starve_test(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int   wait_n;
    logic exp_stall;
`ifdef ARB_STARVE_GUARD_EN
    wait_n    = SL + 1;
    exp_stall = 1'b1;
`else
    wait_n    = 12;
    exp_stall = 1'b0;
`endif
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    host_req = 1'b1; host_we = 1'b0; host_addr = b; host_len = 4'd1;
    for (int j = 0; j < wait_n; j++) begin
      push_cpu(1'b0, a, '0);
      #1;
      chk("starve_no_gnt", 64'(host_gnt), 64'd0);
      cyc();
    end
    if (!exp_stall) begin
      cpu_req = 1'b0;
      #1;
      chk("strict_no_gnt", 64'(host_gnt), 64'd0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      exp_acc.push_back(mk_acc(1'b1, 1'b0, b + AW'(k), '0));
      exp_hrd.push_back(ref_mem[b + AW'(k)]);
    end
    host_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("starve_gnt", 64'(host_gnt), 64'd1);
      chk("starve_stall", 64'(cpu_stall), 64'(exp_stall));
      cyc();
    end
    #1;
    chk("starve_done", 64'(host_done), 64'd1);
    chk("starve_gnt_end", 64'(host_gnt), 64'd0);
    if (exp_stall) begin
      push_cpu(1'b0, a, '0);
      cyc();
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = (i * 32'h0101_0101) ^ 32'hDEAD_0000;
      ref_mem[i] = (i * 32'h0101_0101) ^ 32'hDEAD_0000;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h055; cpu_wdata = 32'h0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h000; host_len = 4'd2;
    host_wdata = 32'h0;

    // Reset held with both sides requesting.
    repeat (3) cyc();
    #1;
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_host_gnt", 64'(host_gnt), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_host_flags", 64'({host_done, host_rvalid}), 64'd0);
    cyc();
    push_cpu(1'b0, 10'h055, '0);
    rst = 1'b1;
    #1;
    chk("release_cpu_access", 64'(mem_en), 64'd1);
    cyc();
    cpu_req = 1'b0; host_req = 1'b0;
    #1;
    chk("release_no_host_gnt", 64'(host_gnt), 64'd0);

    host_burst(1'b1, 10'h100, 4'd3, 32'hA0, -1, '0, '0);
    cpu_access(1'b0, 10'h102, '0);
    host_burst(1'b0, 10'h3FE, 4'd3, -1, -1, '0, '0);
    host_burst(1'b1, 10'h180, 4'd3, -1, 2, 10'h181, 32'h5555_AAAA);
    cpu_access(1'b0, 10'h181, '0);
    starve_test(10'h040, 10'h041);

    // Reset during beat 1 of an 8-beat write burst.
    d0 = $urandom;
    exp_acc.push_back(mk_acc(1'b1, 1'b1, 10'h2F0, d0));
    ref_mem[10'h2F0] = d0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h2F0; host_len = 4'd7; host_wdata = d0;
    cyc();
    host_req = 1'b0;
    #1;
    chk("midrst_gnt_beat0", 64'(host_gnt), 64'd1);
    cyc();
    host_wdata = $urandom;
    rst = 1'b0;
    #1;
    chk("midrst_gnt_drop", 64'(host_gnt), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("midrst_no_done", 64'(host_done), 64'd0);
    cyc();
    host_burst(1'b0, 10'h2EF, 4'd3, -1, -1, '0, '0);

    for (int n = 0; n < 60; n++) begin
      int            op;
      logic [AW-1:0] a;
      logic [3:0]    l;
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1016, 1023))
                                        : AW'($urandom_range(0, 63));
      l  = 4'($urandom);
      case (op)
        0:       cpu_access(1'b1, a, $urandom);
        1:       cpu_access(1'b0, a, '0);
        2:       host_burst(1'($urandom), a, l, -1, -1, '0, '0);
        default: host_burst(1'($urandom), a, l, -1, int'($urandom_range(0, 32'(l))),
                            AW'($urandom_range(0, 63)), $urandom);
      endcase
      repeat ($urandom_range(0, 2)) cyc();
    end

    repeat (4) cyc();
    chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
    chk("hrd_queue_empty", 64'(exp_hrd.size()), 64'd0);
    chk("crd_queue_empty", 64'(exp_crd.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-ported data memory between the pipeline MEM stage and a host loader/unloader. The host moves AES key, state and S-box tables in or out as bursts. The block sits between the EX/MEM register outputs and the data-memory macro. It stalls the pipeline while the host owns the port and sequences host bursts beat by beat. The CPU has priority, with an optional starvation guard for the host.

## Interface
- ADDR_W, 10, data-memory word-address width
- DATA_W, 32, data word width
- STARVE_LIMIT, 8, host wait cycles before a forced grant (guard build only)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM-stage access valid (load or store)
- cpu_we  in  1  MEM-stage store
- cpu_addr  in  ADDR_W  MEM-stage word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data; equals mem_rdata
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; re-present the request
- host_req  in  1  burst request
- host_we  in  1  burst direction (1 = write), sampled at grant
- host_addr  in  ADDR_W  burst base, sampled at grant
- host_len  in  4  beats minus 1 (0..15 → 1..16 beats), sampled at grant
- host_wdata  in  DATA_W  write beat data, consumed each cycle host_gnt=1
- host_gnt  out  1  port owned by host; one beat per cycle
- host_rdata  out  DATA_W  read beat data; equals mem_rdata
- host_rvalid  out  1  host_rdata valid, one cycle after each read beat
- host_done  out  1  one-cycle pulse, cycle after last beat
- mem_en, mem_we  out  1 each  memory enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency

## Operation
- States: CPU_OWN (reset state) and HOST_BURST.
- CPU_OWN:
  - mem_en=cpu_req, mem_we=cpu_req&cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - host_gnt=0, cpu_stall=0.
- CPU_OWN → HOST_BURST when host_req && (!cpu_req || starve_hit).
  - Latch base=host_addr, len=host_len, dir=host_we; clear beat_cnt.
  - A CPU access present in the transition cycle is still served.
- HOST_BURST:
  - mem_en=1, mem_we=dir, mem_addr=(base+beat_cnt) mod 2^ADDR_W (wraps at the top of memory), mem_wdata=host_wdata.
  - host_gnt=1, cpu_stall=cpu_req; CPU requests are never dropped, only held.
- HOST_BURST → CPU_OWN after the beat with beat_cnt==len. Bursts are never preempted.
- host_req deasserting mid-burst is ignored; the full latched length completes.
- Back-to-back bursts: at least one CPU_OWN cycle between bursts, so the CPU gets one slot when cpu_req=1.
- starve_cnt: increments each cycle host_req=1 && state==CPU_OWN && no grant; saturates at STARVE_LIMIT; clears on grant. starve_hit = (starve_cnt==STARVE_LIMIT).

## Timing
- Reset (rst=0, immediate): state=CPU_OWN; host_gnt, host_rvalid, host_done, cpu_stall, mem_en, mem_we = 0; beat_cnt, starve_cnt, latched base/len/dir = 0.
- mem_en/mem_we are forced 0 while rst=0.
- Reset mid-burst aborts the burst with no host_done; memory keeps any beats already written.
- Read latency: mem_rdata and host_rdata are valid the cycle after the access.
- host_rvalid is a registered copy of (host_gnt & !dir).
- Burst of N beats: host_gnt high for exactly N consecutive cycles. host_done is high the cycle after the last beat; for reads, this coincides with the last host_rvalid.
- Grant latency: 1 cycle after host_req when cpu_req=0. With continuous cpu_req, STARVE_LIMIT+1 cycles (guard build) or unbounded (no guard).
- cpu_stall is combinational from state and cpu_req, so the pipeline samples it in the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve_cnt and forced host grant are present as described.
- Undefined: strict CPU priority. The host is granted only in a cycle with cpu_req=0; starve_cnt logic is removed.
- Ports and STARVE_LIMIT exist in both builds.

## Test plan
- Reset: hold rst=0 with cpu_req=1, host_req=1 → mem_en=0, host_gnt=0, cpu_stall=0. Release → CPU access issued the next edge; host not granted that cycle.
- Host write burst: cpu_req=0, host_addr=0x100, host_len=3, host_we=1, data 0xA0..0xA3 → writes to 0x100..0x103 on 4 consecutive cycles, host_done 1 cycle later, then CPU load of 0x102 returns 0xA2.
- Host read burst with wrap: host_addr=0x3FE, host_len=3 → reads 0x3FE, 0x3FF, 0x000, 0x001; host_rvalid high 4 cycles, lagging grant by 1.
- Contention mid-burst: cpu_req=1 raised during beat 2 of a 4-beat burst → cpu_stall=1 until burst ends; the CPU access is served in the first CPU_OWN cycle with the correct address/data.
- Starvation (guard build, STARVE_LIMIT=8): cpu_req held 1, host_req=1 → host_gnt rises on the 10th cycle after host_req. Non-guard build: host_gnt stays 0 until cpu_req drops.
- Reset mid-burst at beat 1 of 8 → host_gnt drops immediately, no host_done, starve_cnt=0, next burst starts cleanly.
